// File: rtl/core_mem_arbiter.sv
// Arbitrates instruction fetch and data memory requests onto one single-beat AXI4 master port.
// Define CORE_ARB_RR_EN for round-robin tie-breaking; otherwise data always beats instruction.
module core_mem_arbiter #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH     = 32
) (
    input  logic                            CLK,
    input  logic                            RST,
    // instruction fetch requester
    input  logic                            I_REQ,
    input  logic [C_ADDR_WIDTH-1:0]         I_ADDR,
    output logic [C_AXI_DATA_WIDTH-1:0]     I_RDATA,
    output logic                            I_ACK,
    // data memory requester
    input  logic                            D_REQ,
    input  logic                            D_WE,
    input  logic [C_ADDR_WIDTH-1:0]         D_ADDR,
    input  logic [C_AXI_DATA_WIDTH-1:0]     D_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   D_WSTRB,
    output logic [C_AXI_DATA_WIDTH-1:0]     D_RDATA,
    output logic                            D_ACK,
    output logic                            ERR,
    // AXI4 read address / data
    output logic [C_ADDR_WIDTH-1:0]         ARADDR,
    output logic                            ARVALID,
    input  logic                            ARREADY,
    output logic [7:0]                      ARLEN,
    output logic [2:0]                      ARSIZE,
    output logic [1:0]                      ARBURST,
    input  logic [C_AXI_DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                      RRESP,
    input  logic                            RVALID,
    output logic                            RREADY,
    // AXI4 write address / data / response
    output logic [C_ADDR_WIDTH-1:0]         AWADDR,
    output logic                            AWVALID,
    input  logic                            AWREADY,
    output logic [7:0]                      AWLEN,
    output logic [2:0]                      AWSIZE,
    output logic [1:0]                      AWBURST,
    output logic [C_AXI_DATA_WIDTH-1:0]     WDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   WSTRB,
    output logic                            WLAST,
    output logic                            WVALID,
    input  logic                            WREADY,
    input  logic [1:0]                      BRESP,
    input  logic                            BVALID,
    output logic                            BREADY
);

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_B, S_ACK} state_t;

    state_t                          state_q, state_d;
    logic                            any_req, grant_data;
    logic                            owner_data_q, aw_done_q, w_done_q, err_q;
    logic [C_ADDR_WIDTH-1:0]         addr_q;
    logic [C_AXI_DATA_WIDTH-1:0]     wdata_q, i_rdata_q, d_rdata_q;
    logic [C_AXI_DATA_WIDTH/8-1:0]   wstrb_q;

    assign any_req = I_REQ | D_REQ;

`ifdef CORE_ARB_RR_EN
    logic last_data_q;

    // On a tie, hand the port to whichever side did not win last time.
    always_comb begin
        grant_data = D_REQ;
        if (D_REQ && I_REQ)
            grant_data = !last_data_q;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            last_data_q <= 1'b0;
        else if (state_q == S_IDLE && any_req)
            last_data_q <= grant_data;
    end
`else
    always_comb begin
        grant_data = D_REQ;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: next-state starts from a default so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (any_req) state_d = (grant_data && D_WE) ? S_AW : S_AR;
            S_AR:   if (ARREADY) state_d = S_R;
            S_R:    if (RVALID)  state_d = S_ACK;
            S_AW:   if ((aw_done_q || AWREADY) && (w_done_q || WREADY)) state_d = S_B;
            S_B:    if (BVALID)  state_d = S_ACK;
            S_ACK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            owner_data_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            err_q        <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Request fields are captured once here; later input changes are ignored.
                    if (any_req) begin
                        owner_data_q <= grant_data;
                        addr_q       <= grant_data ? D_ADDR : I_ADDR;
                        wdata_q      <= D_WDATA;
                        wstrb_q      <= D_WSTRB;
                        aw_done_q    <= 1'b0;
                        w_done_q     <= 1'b0;
                    end
                end
                S_R: begin
                    if (RVALID) begin
                        if (owner_data_q)
                            d_rdata_q <= RDATA;
                        else
                            i_rdata_q <= RDATA;
                        if (RRESP != RESP_OKAY)
                            err_q <= 1'b1;
                    end
                end
                S_AW: begin
                    if (AWREADY) aw_done_q <= 1'b1;
                    if (WREADY)  w_done_q  <= 1'b1;
                end
                S_B: begin
                    if (BVALID && BRESP != RESP_OKAY)
                        err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode flop state only, so AXI inputs never reach AXI outputs combinationally.
    assign ARVALID = (state_q == S_AR);
    assign RREADY  = (state_q == S_R);
    assign AWVALID = (state_q == S_AW) && !aw_done_q;
    assign WVALID  = (state_q == S_AW) && !w_done_q;
    assign BREADY  = (state_q == S_B);
    assign I_ACK   = (state_q == S_ACK) && !owner_data_q;
    assign D_ACK   = (state_q == S_ACK) &&  owner_data_q;

    assign ARADDR  = addr_q;
    assign AWADDR  = addr_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign I_RDATA = i_rdata_q;
    assign D_RDATA = d_rdata_q;
    assign ERR     = err_q;

    assign ARLEN   = 8'd0;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign AWLEN   = 8'd0;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign WLAST   = 1'b1;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: a small AXI slave with per-channel delays and a 16-word RAM.
module tb_core_mem_arbiter;

    logic        CLK, RST;
    logic        I_REQ, I_ACK, D_REQ, D_WE, D_ACK, ERR;
    logic [31:0] I_ADDR, I_RDATA, D_ADDR, D_WDATA, D_RDATA;
    logic [3:0]  D_WSTRB;
    logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
    logic        ARVALID, ARREADY, RVALID, RREADY, AWVALID, AWREADY, WVALID, WREADY, WLAST;
    logic        BVALID, BREADY;
    logic [1:0]  RRESP, BRESP, ARBURST, AWBURST;
    logic [7:0]  ARLEN, AWLEN;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [3:0]  WSTRB;

    core_mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_ACK(I_ACK),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_WSTRB(D_WSTRB),
        .D_RDATA(D_RDATA), .D_ACK(D_ACK), .ERR(ERR),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Slave knobs and bookkeeping
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    logic [1:0]  r_resp, b_resp;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit          r_pend, b_pend, aw_got, w_got;
    logic [3:0]  ar_idx;
    logic [31:0] aw_addr_s, w_data_s;
    logic [3:0]  w_strb_s;
    int          aw_hs = 0;
    int          w_hs = 0;
    logic [31:0] mem [0:15];

    always @(posedge CLK) begin
        if (RST) begin
            r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
            mem[1] = 32'h0000_0013;
        end else begin
            if (ARVALID && ARREADY) begin r_pend = 1; ar_idx = ARADDR[5:2]; end
            if (RVALID && RREADY) r_pend = 0;
            if (AWVALID && AWREADY) begin aw_got = 1; aw_addr_s = AWADDR; aw_hs++; end
            if (WVALID && WREADY) begin w_got = 1; w_data_s = WDATA; w_strb_s = WSTRB; w_hs++; end
            if (BVALID && BREADY) b_pend = 0;
            if (aw_got && w_got && !b_pend) begin
                for (int b = 0; b < 4; b++)
                    if (w_strb_s[b]) mem[aw_addr_s[5:2]][8*b +: 8] = w_data_s[8*b +: 8];
                aw_got = 0; w_got = 0; b_pend = 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0;
            AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            if (ARVALID) begin ARREADY = (ar_cnt >= ar_dly); ar_cnt++; end
            else begin ARREADY = 0; ar_cnt = 0; end
            if (AWVALID) begin AWREADY = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin AWREADY = 0; aw_cnt = 0; end
            if (WVALID) begin WREADY = (w_cnt >= w_dly); w_cnt++; end
            else begin WREADY = 0; w_cnt = 0; end
            if (r_pend) begin
                RVALID = (r_cnt >= r_dly); r_cnt++;
                RDATA = mem[ar_idx]; RRESP = r_resp;
            end else begin RVALID = 0; r_cnt = 0; end
            if (b_pend) begin
                BVALID = (b_cnt >= b_dly); b_cnt++;
                BRESP = b_resp;
            end else begin BVALID = 0; b_cnt = 0; end
        end
    end

    int         checks = 0;
    int         failures = 0;
    int         lat, rready_cycles, aw0, w0;
    bit         other_ack, ack_after;
    logic [4:0] snap [0:15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, hold it until its ACK, then drop it. Optionally scrambles the
    // request inputs one cycle after grant. Snapshots {ARVALID,RREADY,AWVALID,WVALID,BREADY}.
    task automatic do_req(input bit data, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input bit scramble);
        @(negedge CLK);
        if (data) begin
            D_REQ = 1; D_WE = we; D_ADDR = addr; D_WDATA = wdata; D_WSTRB = strb;
        end else begin
            I_REQ = 1; I_ADDR = addr;
        end
        lat = 0; other_ack = 0; rready_cycles = 0;
        for (int i = 0; i < 16; i++) snap[i] = '0;
        do begin
            @(negedge CLK);
            lat++;
            if (lat < 16) snap[lat] = {ARVALID, RREADY, AWVALID, WVALID, BREADY};
            if (RREADY) rready_cycles++;
            if (data ? I_ACK : D_ACK) other_ack = 1;
            if (scramble && lat == 1) begin
                D_ADDR = 32'hFFFF_FFF0; D_WDATA = 32'h1234_5678; D_WSTRB = 4'h0;
                I_ADDR = 32'hFFFF_FFF0;
            end
        end while (!(data ? D_ACK : I_ACK) && lat < 60);
        I_REQ = 0; D_REQ = 0;
        @(negedge CLK);
        ack_after = data ? D_ACK : I_ACK;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int d_at, i_at, d_cnt, i_cnt;

    initial begin
        RST = 1; I_REQ = 0; I_ADDR = '0; D_REQ = 0; D_WE = 0; D_ADDR = '0; D_WDATA = '0; D_WSTRB = '0;
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0; r_resp = 2'b00; b_resp = 2'b00;
        repeat (3) @(negedge CLK);

        check("rst_handshakes", {27'd0, ARVALID, RREADY, AWVALID, WVALID, BREADY}, 32'd0);
        check("rst_ack_err", {29'd0, I_ACK, D_ACK, ERR}, 32'd0);
        check("rst_i_rdata", I_RDATA, 32'd0);
        check("rst_d_rdata", D_RDATA, 32'd0);
        check("ax_constants", {5'd0, ARLEN, ARSIZE, ARBURST, AWLEN, AWSIZE, AWBURST, WLAST},
              {5'd0, 8'd0, 3'b010, 2'b01, 8'd0, 3'b010, 2'b01, 1'b1});
        RST = 0;

        // Zero-wait instruction read
        do_req(0, 0, 32'h0000_0004, 32'd0, 4'h0, 0);
        check("i_read_latency", lat, 3);
        check("i_read_data", I_RDATA, 32'h0000_0013);
        check("i_read_no_d_ack", other_ack, 0);
        check("i_read_ar_phase", snap[1], 5'b10000);
        check("i_read_r_phase", snap[2], 5'b01000);
        check("i_read_ack_one_cycle", ack_after, 0);
        check("i_read_d_rdata_idle", D_RDATA, 32'd0);

        // Write with AWREADY at +1, WREADY at +3; inputs scrambled after grant
        aw_dly = 0; w_dly = 2; aw0 = aw_hs; w0 = w_hs;
        do_req(1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1);
        check("wr_latency", lat, 5);
        check("wr_both_valid", snap[1], 5'b00110);
        check("wr_aw_dropped", snap[2], 5'b00010);
        check("wr_w_waiting", snap[3], 5'b00010);
        check("wr_bready", snap[4], 5'b00001);
        check("wr_aw_once", aw_hs - aw0, 1);
        check("wr_w_once", w_hs - w0, 1);
        check("wr_awaddr_latched", aw_addr_s, 32'h0000_0010);
        check("wr_wdata_latched", w_data_s, 32'hDEAD_BEEF);
        check("wr_ram", mem[4], 32'hDEAD_BEEF);
        check("wr_no_i_ack", other_ack, 0);
        check("wr_ack_one_cycle", ack_after, 0);

        // Partial-strobe write
        w_dly = 0;
        do_req(1, 1, 32'h0000_0014, 32'h1122_3344, 4'b0101, 0);
        check("wr_strb_latency", lat, 3);
        check("wr_strb_wstrb", w_strb_s, 4'b0101);
        check("wr_strb_ram", mem[5], 32'hA022_0044);

        // Reads from both owners: each RDATA holds until its own next completion
        do_req(0, 0, 32'h0000_0010, 32'd0, 4'h0, 1);
        check("i_read_latched_addr", I_RDATA, 32'hDEAD_BEEF);
        do_req(1, 0, 32'h0000_0014, 32'd0, 4'h0, 0);
        check("d_read_data", D_RDATA, 32'hA022_0044);
        check("d_read_i_rdata_held", I_RDATA, 32'hDEAD_BEEF);
        check("d_read_err_clear", ERR, 0);

        // Slow read with SLVERR
        r_dly = 10; r_resp = 2'b10;
        do_req(0, 0, 32'h0000_0000, 32'd0, 4'h0, 0);
        check("slow_read_latency", lat, 13);
        check("slow_read_rready_held", rready_cycles, 11);
        check("slow_read_err", ERR, 1);
        check("slow_read_data", I_RDATA, 32'hA000_0000);
        r_dly = 0; r_resp = 2'b00;
        do_req(1, 0, 32'h0000_0010, 32'd0, 4'h0, 0);
        check("err_sticky", ERR, 1);
        check("d_read_after_err", D_RDATA, 32'hDEAD_BEEF);

        // Reset while waiting in R
        r_dly = 5;
        @(negedge CLK);
        I_REQ = 1; I_ADDR = 32'h0000_0004;
        repeat (3) @(negedge CLK);
        check("rst_mid_in_r", RREADY, 1);
        RST = 1; I_REQ = 0;
        @(negedge CLK);
        check("rst_mid_outputs", {26'd0, ARVALID, RREADY, AWVALID, WVALID, BREADY, I_ACK}, 32'd0);
        check("rst_mid_err_rdata", {D_ACK, ERR, I_RDATA[29:0]}, 32'd0);
        RST = 0; r_dly = 0;
        repeat (2) @(negedge CLK);
        check("rst_mid_no_ack", {I_ACK, D_ACK}, 0);
        do_req(0, 0, 32'h0000_0004, 32'd0, 4'h0, 0);
        check("post_rst_latency", lat, 3);
        check("post_rst_data", I_RDATA, 32'h0000_0013);

        // Simultaneous requests, each dropped on its own ACK
        @(negedge CLK);
        I_ADDR = 32'h0000_0008; I_REQ = 1;
        D_ADDR = 32'h0000_000C; D_WE = 0; D_REQ = 1;
        d_at = -1; i_at = -1; d_cnt = 0; i_cnt = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge CLK);
            if (D_ACK) begin d_cnt++; if (d_at < 0) d_at = n; D_REQ = 0; end
            if (I_ACK) begin i_cnt++; if (i_at < 0) i_at = n; I_REQ = 0; end
        end
        check("tie_d_first", d_at, 3);
        check("tie_i_period", i_at, 7);
        check("tie_d_one_ack", d_cnt, 1);
        check("tie_i_one_ack", i_cnt, 1);
        check("tie_d_data", D_RDATA, 32'hA000_0003);
        check("tie_i_data", I_RDATA, 32'hA000_0002);

        // Write with SLVERR response
        b_resp = 2'b10;
        do_req(1, 1, 32'h0000_0018, 32'h0000_0055, 4'hF, 0);
        check("bresp_latency", lat, 3);
        check("bresp_err", ERR, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
